// File: rtl/frame_pkg.sv
// Shared types and geometry for the double-buffered 8x8 frame store.
package frame_pkg;

    localparam int unsigned ROW_COUNT = 8;
    localparam int unsigned ROW_WIDTH = 8;
    localparam int unsigned ADDR_W    = $clog2(ROW_COUNT);
    localparam int unsigned FRAME_W   = ROW_COUNT * ROW_WIDTH;

    typedef enum logic {
        IDLE,
        WAIT_END
    } state_t;

endpackage

// File: rtl/frame_buffer_if.sv
// Row-write handshake, commit/frame-end strobes and front-buffer status.
interface frame_buffer_if;
    import frame_pkg::*;

    logic                WR_VALID;
    logic                WR_READY;
    logic [ADDR_W-1:0]   WR_ADDR;
    logic [ROW_WIDTH-1:0] WR_DATA;
    logic                COMMIT;
    logic                FRAME_END;
    logic [FRAME_W-1:0]  FRAME;
    logic                PENDING;
    logic                DONE;

    modport master (
        output WR_VALID, WR_ADDR, WR_DATA, COMMIT, FRAME_END,
        input  WR_READY, FRAME, PENDING, DONE
    );

    modport slave (
        input  WR_VALID, WR_ADDR, WR_DATA, COMMIT, FRAME_END,
        output WR_READY, FRAME, PENDING, DONE
    );
endinterface

// File: rtl/frame_row_bank.sv
// 8x8 back bank: one row write port, whole image readable as a flat word.
module frame_row_bank
    import frame_pkg::*;
#(
    parameter logic [FRAME_W-1:0] INIT_PATTERN = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [ROW_WIDTH-1:0] wr_data,
    output logic [FRAME_W-1:0]   rd_data
);

    logic [ROW_COUNT-1:0][ROW_WIDTH-1:0] rows_q;
    logic [ROW_COUNT-1:0][ROW_WIDTH-1:0] rows_d;

    always_comb begin
        rows_d = rows_q;
        if (wr_en) begin
            rows_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q <= INIT_PATTERN;
        end else begin
            rows_q <= rows_d;
        end
    end

    assign rd_data = rows_q;

endmodule

// File: rtl/frame_buffer.sv
// Double-buffered frame store: rows land in the back bank, and a commit copies
// the whole image to the front bank only at the next frame boundary.
module frame_buffer
    import frame_pkg::*;
#(
    parameter logic [FRAME_W-1:0] INIT_PATTERN = 64'h0
) (
    input  logic           CLK,
    input  logic           RESET,
    frame_buffer_if.slave  bus
);

    state_t               state_q, state_d;
    logic [FRAME_W-1:0]   front_q, front_d;
    logic                 done_q, done_d;
    logic [FRAME_W-1:0]   back_data;
    logic                 wr_fire;

    // Writes are accepted only in IDLE, so the back image is frozen while a
    // swap is pending and the copy at FRAME_END is always a complete frame.
    assign wr_fire = bus.WR_VALID && (state_q == IDLE);

    frame_row_bank #(
        .INIT_PATTERN (INIT_PATTERN)
    ) u_back (
        .clk     (CLK),
        .rst     (RESET),
        .wr_en   (wr_fire),
        .wr_addr (bus.WR_ADDR),
        .wr_data (bus.WR_DATA),
        .rd_data (back_data)
    );

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.COMMIT) begin
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (bus.FRAME_END) begin
                    front_d = back_data;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            front_q <= INIT_PATTERN;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            done_q  <= done_d;
        end
    end

    assign bus.WR_READY = (state_q == IDLE);
    assign bus.PENDING  = (state_q == WAIT_END);
    assign bus.FRAME    = front_q;
    assign bus.DONE     = done_q;

endmodule

// File: tb/tb_frame_buffer.sv
// Directed bench for frame_buffer with hand-computed expected frames.
module tb_frame_buffer;
    import frame_pkg::*;

    localparam logic [63:0] INIT = 64'hA5A5_0000_FFFF_0001;
    localparam logic [63:0] F1   = 64'hA5A5_0000_81FF_0001;
    localparam logic [63:0] F2   = 64'hA5A5_0000_81FF_5A01;
    localparam logic [63:0] F3   = 64'h3CA5_0000_81FF_5A01;

    logic clk;
    logic rst;
    int   vectors;
    int   errors;

    frame_buffer_if bus ();

    frame_buffer #(
        .INIT_PATTERN (INIT)
    ) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.WR_VALID  = 1'b0;
        bus.WR_ADDR   = '0;
        bus.WR_DATA   = '0;
        bus.COMMIT    = 1'b0;
        bus.FRAME_END = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        rst = 1'b1;
        idle_inputs();
        #3;
        check("rst_frame",   bus.FRAME,    INIT);
        check("rst_ready",   bus.WR_READY, 1);
        check("rst_pending", bus.PENDING,  0);
        check("rst_done",    bus.DONE,     0);
        @(negedge clk);
        rst = 1'b0;

        // Row 3 write, commit, frame end ten cycles after the commit
        bus.WR_VALID = 1'b1; bus.WR_ADDR = 3'd3; bus.WR_DATA = 8'h81;
        tick();
        idle_inputs();
        bus.COMMIT = 1'b1;
        tick();
        idle_inputs();
        check("c1_pending", bus.PENDING,  1);
        check("c1_ready",   bus.WR_READY, 0);
        check("c1_hold",    bus.FRAME,    INIT);
        repeat (8) tick();
        check("c1_nodone", bus.DONE,  0);
        check("c1_stable", bus.FRAME, INIT);
        tick();
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c1_frame",   bus.FRAME,    F1);
        check("c1_done",    bus.DONE,     1);
        check("c1_idle",    bus.PENDING,  0);
        check("c1_readyup", bus.WR_READY, 1);
        tick();
        check("c1_done1cy", bus.DONE,  0);
        check("c1_keep",    bus.FRAME, F1);

        // COMMIT and FRAME_END together in IDLE: frame end is ignored
        bus.WR_VALID = 1'b1; bus.WR_ADDR = 3'd1; bus.WR_DATA = 8'h5A;
        tick();
        idle_inputs();
        check("c2_nowrfront", bus.FRAME, F1);
        bus.COMMIT = 1'b1; bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c2_pending", bus.PENDING, 1);
        check("c2_hold",    bus.FRAME,   F1);
        check("c2_nodone",  bus.DONE,    0);
        tick();
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c2_frame", bus.FRAME, F2);
        check("c2_done",  bus.DONE,  1);
        tick();

        // Write and second commit while WAIT_END are both dropped
        bus.COMMIT = 1'b1;
        tick();
        idle_inputs();
        bus.WR_VALID = 1'b1; bus.WR_ADDR = 3'd0; bus.WR_DATA = 8'hFF;
        bus.COMMIT = 1'b1;
        #1;
        check("c3_notready", bus.WR_READY, 0);
        tick();
        idle_inputs();
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c3_frame", bus.FRAME, F2);
        check("c3_done",  bus.DONE,  1);
        repeat (2) tick();
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c3_nodone2", bus.DONE,    0);
        check("c3_idle",    bus.PENDING, 0);
        check("c3_keep",    bus.FRAME,   F2);

        // Write accepted in the same cycle as COMMIT is part of the image
        bus.WR_VALID = 1'b1; bus.WR_ADDR = 3'd7; bus.WR_DATA = 8'h3C;
        bus.COMMIT = 1'b1;
        tick();
        idle_inputs();
        check("c4_pending", bus.PENDING, 1);
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c4_frame", bus.FRAME, F3);
        check("c4_done",  bus.DONE,  1);
        tick();

        // Asynchronous reset in the middle of WAIT_END abandons the commit
        bus.WR_VALID = 1'b1; bus.WR_ADDR = 3'd4; bus.WR_DATA = 8'h77;
        bus.COMMIT = 1'b1;
        tick();
        idle_inputs();
        check("c5_pending", bus.PENDING, 1);
        #2 rst = 1'b1;
        #1;
        check("c5_frame",   bus.FRAME,    INIT);
        check("c5_pending0", bus.PENDING, 0);
        check("c5_ready",   bus.WR_READY, 1);
        check("c5_done",    bus.DONE,     0);
        @(negedge clk);
        rst = 1'b0;
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c5_nodone", bus.DONE,    0);
        check("c5_keep",   bus.FRAME,   INIT);
        check("c5_idle",   bus.PENDING, 0);

        // First cycles after reset release behave normally; back was reset too
        bus.COMMIT = 1'b1;
        tick();
        idle_inputs();
        bus.FRAME_END = 1'b1;
        tick();
        idle_inputs();
        check("c6_done",  bus.DONE,  1);
        check("c6_frame", bus.FRAME, INIT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
